mem_access_unit: RTL



---
 rtl/mem_access_pkg.sv | 32 +++
 rtl/data_memory_be.sv | 46 ++++
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings, FSM states and load extraction for the MEM-stage unit
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_DATA_BASE = 32'h1001_0000;
    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 4;

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = word[16*lane[1] +: 16];
        case (size)
            SIZE_BYTE: return uns ? {24'd0, b} : {{24{b[7]}}, b};
            SIZE_HALF: return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default:   return word;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_be.sv
// rtl/data_memory_be.sv - word RAM with per-byte write enables and a registered read port
module data_memory_be #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        byte_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'd0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with address check, sized access and read latency
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int          NBits        = 32,
    parameter int          MEMORY_DEPTH = 512,
    parameter logic [31:0] DATA_BASE    = DEFAULT_DATA_BASE,
    parameter int          READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic             MemRead,
    input  logic [1:0]       MemSize,
    input  logic             MemUnsigned,
    input  logic [NBits-1:0] ALUResult,
    input  logic [NBits-1:0] WriteData,
    output logic [NBits-1:0] MemoryData,
    output logic [NBits-1:0] DataAddress,
    output logic             Stall,
    output logic             Valid,
    output logic             Fault,
    output logic [NBits-1:0] FaultAddress
);

    localparam int ADDR_W = $clog2(MEMORY_DEPTH);
    localparam int LAT = (READ_LATENCY < MIN_READ_LATENCY) ? MIN_READ_LATENCY :
                         (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;
    localparam logic [1:0]  WAIT_INIT = (LAT >= 2) ? 2'(LAT - 2) : 2'd0;
    localparam logic [31:0] SEG_BYTES = 32'(MEMORY_DEPTH * 4);

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          lane_q, lane_d, size_q, size_d;
    logic                uns_q, uns_d;
    logic [1:0]          ld_lane_q, ld_lane_d, ld_size_q, ld_size_d;
    logic                ld_uns_q, ld_uns_d;
    logic                fault_q, fault_d;
    logic [31:0]         fault_addr_q, fault_addr_d;

    logic [31:0]         offset;
    logic                accepting, bad, rd_go, wr_go, load_en;
    logic [3:0]          be;
    logic [31:0]         wdata_lanes, rdata;
    logic [ADDR_W-1:0]   raddr;

    assign offset = ALUResult - DATA_BASE;

    always_comb begin
        accepting = (state_q != WAIT);
        bad = (MemSize == SIZE_HALF && offset[0]) ||
              (MemSize == SIZE_WORD && offset[1:0] != 2'b00) ||
              (MemSize == 2'b11) || (offset >= SEG_BYTES) || (MemRead && MemWrite);
        rd_go = accepting && MemRead && !bad;
        wr_go = accepting && MemWrite && !bad;
        fault_d = accepting && (MemRead || MemWrite) && bad;
        fault_addr_d = fault_d ? ALUResult : fault_addr_q;

        case (MemSize)
            SIZE_BYTE: begin be = 4'b0001 << offset[1:0]; wdata_lanes = {4{WriteData[7:0]}}; end
            SIZE_HALF: begin be = offset[1] ? 4'b1100 : 4'b0011; wdata_lanes = {2{WriteData[15:0]}}; end
            default:   begin be = 4'b1111; wdata_lanes = WriteData; end
        endcase
        if (!wr_go || reset) begin
            be = 4'b0000;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        lane_d    = lane_q;
        size_d    = size_q;
        uns_d     = uns_q;
        ld_lane_d = ld_lane_q;
        ld_size_d = ld_size_q;
        ld_uns_d  = ld_uns_q;
        load_en   = 1'b0;
        raddr     = addr_q;
        case (state_q)
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d   = RESP;
                    load_en   = 1'b1;
                    ld_lane_d = lane_q;
                    ld_size_d = size_q;
                    ld_uns_d  = uns_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                raddr   = offset[ADDR_W+1:2];
                if (rd_go) begin
                    addr_d = offset[ADDR_W+1:2];
                    lane_d = offset[1:0];
                    size_d = MemSize;
                    uns_d  = MemUnsigned;
                    if (LAT == 1) begin
                        state_d   = RESP;
                        load_en   = 1'b1;
                        ld_lane_d = offset[1:0];
                        ld_size_d = MemSize;
                        ld_uns_d  = MemUnsigned;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            addr_q       <= '0;
            lane_q       <= 2'd0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            ld_lane_q    <= 2'd0;
            ld_size_q    <= 2'd0;
            ld_uns_q     <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            ld_lane_q    <= ld_lane_d;
            ld_size_q    <= ld_size_d;
            ld_uns_q     <= ld_uns_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    data_memory_be #(.DEPTH(MEMORY_DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .byte_en (be),
        .waddr   (offset[ADDR_W+1:2]),
        .wdata   (wdata_lanes),
        .rd_en   (load_en && !reset),
        .raddr   (raddr),
        .rdata   (rdata)
    );

    // Extraction sits after the RAM read register; its controls only change when new data lands.
    assign MemoryData   = extract_load(rdata, ld_lane_q, ld_size_q, ld_uns_q);
    assign DataAddress  = offset;
    assign Stall        = rd_go || (state_q == WAIT);
    assign Valid        = (state_q == RESP);
    assign Fault        = fault_q;
    assign FaultAddress = fault_addr_q;

endmodule
